// File: rtl/control_unit_pkg.sv
// Shared definitions for the 16-bit accumulator processor sequencer.
// Holds the opcode map, the sequencer state encoding and default widths so
// that the control unit, the instruction decoder and the ALU agree on them.
package control_unit_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned AddrWDefault = 12;
  localparam int unsigned OpcodeW      = 4;

  // Opcode map, IR[15:12]. 1011..1110 are unassigned and behave as NOP.
  localparam logic [OpcodeW-1:0] OpNop   = 4'b0000;
  localparam logic [OpcodeW-1:0] OpAdd   = 4'b0001;
  localparam logic [OpcodeW-1:0] OpSub   = 4'b0010;
  localparam logic [OpcodeW-1:0] OpAnd   = 4'b0011;
  localparam logic [OpcodeW-1:0] OpOr    = 4'b0100;
  localparam logic [OpcodeW-1:0] OpXor   = 4'b0101;
  localparam logic [OpcodeW-1:0] OpNot   = 4'b0110;
  localparam logic [OpcodeW-1:0] OpLoad  = 4'b0111;
  localparam logic [OpcodeW-1:0] OpStore = 4'b1000;
  localparam logic [OpcodeW-1:0] OpJmp   = 4'b1001;
  localparam logic [OpcodeW-1:0] OpJz    = 4'b1010;
  localparam logic [OpcodeW-1:0] OpHalt  = 4'b1111;

  // Sequencer states.
  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StRead    = 3'd2,
    StCapture = 3'd3,
    StExecute = 3'd4,
    StWrite   = 3'd5,
    StHalt    = 3'd6
  } state_e;

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational instruction classifier.
// Maps a 4-bit opcode to the class flags the sequencer branches on.
//   opcode_i        : instruction opcode field
//   is_alu_o        : ADD/SUB/AND/OR/XOR/NOT (result comes from the ALU)
//   needs_operand_o : instruction reads a memory operand into MDR first
//   is_load_o       : LOAD (ACC <= MDR, ALU not involved)
//   is_store_o      : STORE
//   is_jmp_o        : unconditional jump
//   is_jz_o         : jump if accumulator is zero
//   is_halt_o       : HALT
module control_unit_instr_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_alu_o,
  output logic       needs_operand_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_jmp_o,
  output logic       is_jz_o,
  output logic       is_halt_o
);

  always_comb begin
    is_alu_o        = 1'b0;
    needs_operand_o = 1'b0;
    is_load_o       = 1'b0;
    is_store_o      = 1'b0;
    is_jmp_o        = 1'b0;
    is_jz_o         = 1'b0;
    is_halt_o       = 1'b0;
    case (opcode_i)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        is_alu_o        = 1'b1;
        needs_operand_o = 1'b1;
      end
      // NOT works on ACC alone, so it skips the operand fetch.
      OpNot:   is_alu_o = 1'b1;
      OpLoad: begin
        is_load_o       = 1'b1;
        needs_operand_o = 1'b1;
      end
      OpStore: is_store_o = 1'b1;
      OpJmp:   is_jmp_o   = 1'b1;
      OpJz:    is_jz_o    = 1'b1;
      OpHalt:  is_halt_o  = 1'b1;
      default: ;  // NOP and unassigned opcodes
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator processor.
// Owns PC, IR, MDR and ACC, drives the single-port unified memory and acts as
// the initiator towards an external combinational ALU.
//   clk_i         : rising-edge clock
//   rst_ni        : asynchronous active-low reset
//   mem_addr_o    : memory address (PC while fetching, IR address otherwise)
//   mem_rd_en_o   : read strobe; mem_rdata_i is valid one cycle later
//   mem_wr_en_o   : write strobe; memory writes at the rising edge
//   mem_wdata_o   : write data, always ACC
//   mem_rdata_i   : memory read data
//   alu_num1_o    : ALU operand 1 (ACC)
//   alu_num2_o    : ALU operand 2 (MDR)
//   alu_opcode_o  : ALU operation, zero unless executing an ALU instruction
//   alu_result_i  : ALU result
//   acc_o, pc_o   : architectural accumulator and program counter
//   zero_o        : ACC == 0
//   halted_o      : sequencer is in the HALT state
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned         DATA_W   = DataWDefault,
  parameter int unsigned         ADDR_W   = AddrWDefault,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] alu_num1_o,
  output logic [DATA_W-1:0] alu_num2_o,
  output logic [3:0]        alu_opcode_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              zero_o,
  output logic              halted_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  logic [3:0]        dec_opcode;
  logic [3:0]        ir_opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] rdata_addr;
  logic              acc_zero;

  logic is_alu, needs_operand, is_load, is_store, is_jmp, is_jz, is_halt;

  assign ir_opcode  = ir_q[DATA_W-1 -: 4];
  assign ir_addr    = ir_q[ADDR_W-1:0];
  assign rdata_addr = mem_rdata_i[ADDR_W-1:0];
  assign acc_zero   = (acc_q == '0);

  // In DECODE the instruction is still on the read bus (IR loads at the end
  // of that cycle), so classify the bus; in every later state use IR.
  assign dec_opcode = (state_q == StDecode) ? mem_rdata_i[DATA_W-1 -: 4] : ir_opcode;

  control_unit_instr_decode u_instr_decode (
    .opcode_i        (dec_opcode),
    .is_alu_o        (is_alu),
    .needs_operand_o (needs_operand),
    .is_load_o       (is_load),
    .is_store_o      (is_store),
    .is_jmp_o        (is_jmp),
    .is_jz_o         (is_jz),
    .is_halt_o       (is_halt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (needs_operand) begin
          state_d = StRead;
        end else if (is_alu) begin
          state_d = StExecute;  // NOT
        end else if (is_store) begin
          state_d = StWrite;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StRead:    state_d = StCapture;
      StCapture: state_d = StExecute;
      StExecute: state_d = StFetch;
      StWrite:   state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  // Output logic. Read strobe is gated by reset so it is low while held.
  always_comb begin
    mem_addr_o   = pc_q;
    mem_rd_en_o  = 1'b0;
    mem_wr_en_o  = 1'b0;
    alu_opcode_o = OpNop;
    unique case (state_q)
      StFetch: mem_rd_en_o = rst_ni;
      StRead: begin
        mem_addr_o  = ir_addr;
        mem_rd_en_o = 1'b1;
      end
      StExecute: begin
        if (is_alu) begin
          alu_opcode_o = ir_opcode;
        end
      end
      StWrite: begin
        mem_addr_o  = ir_addr;
        mem_wr_en_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;
    acc_d = acc_q;
    unique case (state_q)
      StDecode: begin
        ir_d = mem_rdata_i;
        // JZ looks at the ACC left by the previous instruction.
        if (is_jmp || (is_jz && acc_zero)) begin
          pc_d = rdata_addr;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      StCapture: mdr_d = mem_rdata_i;
      StExecute: begin
        if (is_load) begin
          acc_d = mdr_q;
        end else if (is_alu) begin
          acc_d = alu_result_i;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
      acc_q <= acc_d;
    end
  end

  assign mem_wdata_o = acc_q;
  assign alu_num1_o  = acc_q;
  assign alu_num2_o  = mdr_q;
  assign acc_o       = acc_q;
  assign pc_o        = pc_q;
  assign zero_o      = acc_zero;
  assign halted_o    = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model
// producing a per-cycle bus trace, directed programs plus random programs.
module tb_control_unit;

  logic        clk;
  logic        rst_ni;
  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic [15:0] acc;
  logic [11:0] pc;
  logic        zero;
  logic        halted;

  control_unit #(
    .DATA_W   (16),
    .ADDR_W   (12),
    .RESET_PC (12'h000)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mem_addr_o   (mem_addr),
    .mem_rd_en_o  (mem_rd_en),
    .mem_wr_en_o  (mem_wr_en),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .alu_num1_o   (alu_num1),
    .alu_num2_o   (alu_num2),
    .alu_opcode_o (alu_opcode),
    .alu_result_i (alu_result),
    .acc_o        (acc),
    .pc_o         (pc),
    .zero_o       (zero),
    .halted_o     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a & b;
      4'h4:    return a | b;
      4'h5:    return a ^ b;
      4'h6:    return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference ALU beside the DUT.
  always_comb alu_result = alu_f(alu_opcode, alu_num1, alu_num2);

  // Memory: img is the program image, copied in while load_req is high.
  logic [15:0] img [4096];
  logic [15:0] mem [4096];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end
  end

  // Expected per-cycle bus activity; arch marks an instruction boundary.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  aop;
    logic        hlt;
    logic [15:0] wdata;
    logic        arch;
    logic [15:0] acc;
    logic [11:0] pc;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] m_mem [4096];
  logic [11:0] m_pc;
  logic [15:0] m_acc;
  logic        m_halted;
  logic        chk_en = 1'b0;

  function automatic exp_t mk(input logic rd, input logic wr, input logic [11:0] addr,
                              input logic [3:0] aop, input logic hlt);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.aop = aop; e.hlt = hlt;
    e.wdata = '0; e.arch = 1'b0; e.acc = '0; e.pc = '0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_mem[i] = img[i];
    m_pc = 12'h000;
    m_acc = 16'h0000;
    m_halted = 1'b0;
    expq.delete();
  endtask

  // Execute one instruction and queue the cycles it takes on the bus.
  task automatic iss_step();
    exp_t        e;
    logic [15:0] w;
    logic [3:0]  op;
    logic [11:0] a, p, npc;
    if (m_halted) begin
      expq.push_back(mk(1'b0, 1'b0, m_pc, 4'h0, 1'b1));
      return;
    end
    p = m_pc; w = m_mem[p]; op = w[15:12]; a = w[11:0];
    e = mk(1'b1, 1'b0, p, 4'h0, 1'b0);
    e.arch = 1'b1; e.acc = m_acc; e.pc = p;
    expq.push_back(e);
    expq.push_back(mk(1'b0, 1'b0, p, 4'h0, 1'b0));
    npc = p + 12'd1;
    if (op == 4'h9 || (op == 4'hA && m_acc == 16'h0)) npc = a;
    if ((op >= 4'h1 && op <= 4'h5) || op == 4'h7) begin
      expq.push_back(mk(1'b1, 1'b0, a, 4'h0, 1'b0));
      expq.push_back(mk(1'b0, 1'b0, npc, 4'h0, 1'b0));
      expq.push_back(mk(1'b0, 1'b0, npc, (op == 4'h7) ? 4'h0 : op, 1'b0));
      m_acc = (op == 4'h7) ? m_mem[a] : alu_f(op, m_acc, m_mem[a]);
    end else if (op == 4'h6) begin
      expq.push_back(mk(1'b0, 1'b0, npc, 4'h6, 1'b0));
      m_acc = ~m_acc;
    end else if (op == 4'h8) begin
      e = mk(1'b0, 1'b1, a, 4'h0, 1'b0);
      e.wdata = m_acc;
      expq.push_back(e);
      m_mem[a] = m_acc;
    end else if (op == 4'hF) begin
      m_halted = 1'b1;
    end
    m_pc = npc;
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!chk_en) begin
      model_reset();
    end else begin
      if (expq.size() == 0) iss_step();
      e = expq.pop_front();
      check("mem_rd_en", mem_rd_en, e.rd);
      check("mem_wr_en", mem_wr_en, e.wr);
      check("mem_addr", mem_addr, e.addr);
      check("alu_opcode", alu_opcode, e.aop);
      check("halted", halted, e.hlt);
      if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
      if (e.arch) begin
        check("acc", acc, e.acc);
        check("pc", pc, e.pc);
        check("zero", zero, e.acc == 16'h0);
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
  endtask

  // Reset, load img, release, run ncyc edges; hc = first edge after which halted.
  task automatic run_prog(input int ncyc, output int hc);
    rst_ni = 1'b0;
    chk_en = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;
    hc = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (halted && hc < 0) hc = k;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 55)      op = 4'($urandom_range(1, 5));
    else if (r < 62) op = 4'h7;
    else if (r < 72) op = 4'h8;
    else if (r < 78) op = 4'h6;
    else if (r < 86) op = ($urandom_range(0, 1) == 0) ? 4'h9 : 4'hA;
    else if (r < 97) op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(11, 14));
    else             op = 4'hF;
    return {op, 12'($urandom_range(0, 4095))};
  endfunction

  logic [15:0] logic_ops [4];
  logic [15:0] logic_exp [4];

  initial begin
    int hc;
    bit seen;
    rst_ni = 1'b0;
    mem_rdata = 16'h0000;

    // Reset asserted in the middle of a STORE.
    clear_img();
    img[0] = 16'h8020;
    rst_ni = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    check("reset_rd_en", mem_rd_en, 1'b0);
    check("reset_zero", zero, 1'b1);
    check("reset_addr", mem_addr, 12'h000);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (mem_wr_en) seen = 1'b1;
    end
    check("write_reached", seen, 1'b1);
    check("pc_before_reset", pc, 12'h001);
    rst_ni = 1'b0;
    #1;
    check("reset_wr_drop", mem_wr_en, 1'b0);
    check("reset_pc", pc, 12'h000);
    check("reset_acc", acc, 16'h0000);
    check("reset_halted", halted, 1'b0);
    check("reset_aluop", alu_opcode, 4'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    #1;
    check("first_fetch_rd", mem_rd_en, 1'b1);
    check("first_fetch_addr", mem_addr, 12'h000);

    // Arithmetic program: LOAD, ADD, SUB, HALT.
    clear_img();
    img[0] = 16'h7010; img[1] = 16'h1011; img[2] = 16'h2011; img[3] = 16'hF000;
    img[12'h010] = 16'h0009; img[12'h011] = 16'h0003;
    run_prog(5, hc);
    check("arith_load", acc, 16'h0009);
    run_prog(10, hc);
    check("arith_add", acc, 16'h000C);
    run_prog(25, hc);
    check("arith_sub", acc, 16'h0009);
    check("arith_pc", pc, 12'h004);
    check("arith_halted", halted, 1'b1);
    check("arith_halt_cycle", hc, 17);

    // Logic ops on 0x0009 with operand 0x0003.
    logic_ops[0] = 16'h3011; logic_exp[0] = 16'h0001;
    logic_ops[1] = 16'h4011; logic_exp[1] = 16'h000B;
    logic_ops[2] = 16'h5011; logic_exp[2] = 16'h000A;
    logic_ops[3] = 16'h6000; logic_exp[3] = 16'hFFF6;
    for (int i = 0; i < 4; i++) begin
      clear_img();
      img[0] = 16'h7010; img[1] = logic_ops[i]; img[2] = 16'hF000;
      img[12'h010] = 16'h0009; img[12'h011] = 16'h0003;
      run_prog(20, hc);
      check("logic_acc", acc, logic_exp[i]);
    end

    // STORE then LOAD the same location.
    clear_img();
    img[0] = 16'h7010; img[1] = 16'h8020; img[2] = 16'h2010; img[3] = 16'h7020;
    img[4] = 16'hF000; img[12'h010] = 16'h1234;
    run_prog(30, hc);
    check("store_mem", mem[12'h020], 16'h1234);
    check("store_load_acc", acc, 16'h1234);

    // JZ taken, JMP to 0xFFF, PC wrap, JZ not taken.
    clear_img();
    img[0] = 16'hA002; img[1] = 16'hF000; img[2] = 16'h7010; img[3] = 16'h9FFF;
    img[12'hFFF] = 16'h0000; img[12'h010] = 16'h0001;
    run_prog(30, hc);
    check("branch_pc", pc, 12'h002);
    check("branch_acc", acc, 16'h0001);
    check("branch_halted", halted, 1'b1);

    // Unassigned opcode behaves as NOP.
    clear_img();
    img[0] = 16'h7010; img[1] = 16'hC123; img[2] = 16'hF000; img[12'h010] = 16'h00AB;
    run_prog(15, hc);
    check("undef_acc", acc, 16'h00AB);
    check("undef_pc", pc, 12'h003);

    // Random programs covering the whole address space.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 4096; i++) img[i] = rand_instr();
      run_prog(600, hc);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
